// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE bus feeder: FSM state encoding and skid-buffer sizing.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    STREAM,
    DONE
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/pe_feeder_skid_buf.sv
// Two-entry skid buffer between the GBUF read return and the PE port; slot0 is always the head.
module pe_feeder_skid_buf
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [OCC_WIDTH-1:0]  count;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < OCC_WIDTH'(SKID_DEPTH)) || do_pop);
  assign head      = slot0;
  assign empty     = (count == '0);
  assign occupancy = count;

  // A simultaneous push and pop keeps the count; the new word lands behind whatever survives the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) slot0 <= push_data;
          else             slot1 <= push_data;
          count <= count + OCC_WIDTH'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - OCC_WIDTH'(1);
        end
        2'b11: begin
          if (count == OCC_WIDTH'(1)) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_bus_feeder.sv
// Streams a run of GBUF words into one PE input port with start-load pulse and FIFO-full gating.
// Optional PE_FEEDER_STRIDE_EN adds cmd_stride; otherwise addresses advance by 1.
module pe_bus_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_full_column,
`ifdef PE_FEEDER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  gbuf_rd_en,
  output logic [ADDR_WIDTH-1:0] gbuf_rd_addr,
  input  logic [DATA_WIDTH-1:0] gbuf_rd_data,
  output logic                  pe_start_load,
  output logic                  pe_load_full_column,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  pe_data_en,
  input  logic                  pe_fifo_full,
  output logic                  busy,
  output logic                  done
);

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [LEN_WIDTH-1:0]   issued_cnt;
  logic [LEN_WIDTH-1:0]   xfer_cnt;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [ADDR_WIDTH-1:0]  stride;
  logic                   in_flight;
  logic                   accept;
  logic                   pop;
  logic                   buf_empty;
  logic [OCC_WIDTH-1:0]   occupancy;
  logic [OCC_WIDTH:0]     pending;
  logic                   rd_space;

`ifdef PE_FEEDER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         stride_r <= '0;
    else if (accept) stride_r <= cmd_stride;
  end

  assign stride = stride_r;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  assign accept     = cmd_valid && cmd_ready;
  assign pop        = !buf_empty && !pe_fifo_full;
  assign pe_data_en = pop;

  // Words already buffered or in flight, less the one leaving now, must leave room for a new read.
  assign pending    = {1'b0, occupancy} + {{OCC_WIDTH{1'b0}}, in_flight};
  assign rd_space   = pending < ((OCC_WIDTH+1)'(SKID_DEPTH) + {{OCC_WIDTH{1'b0}}, pop});
  assign gbuf_rd_en = ((state == START) || (state == STREAM)) && (issued_cnt < len_r) && rd_space;
  assign gbuf_rd_addr = addr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= '0;
      issued_cnt <= '0;
      xfer_cnt   <= '0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= gbuf_rd_en;
      if (accept) begin
        addr_r     <= cmd_base_addr;
        issued_cnt <= '0;
        xfer_cnt   <= '0;
      end else begin
        if (gbuf_rd_en) begin
          addr_r     <= addr_r + stride;
          issued_cnt <= issued_cnt + LEN_WIDTH'(1);
        end
        if (pop) xfer_cnt <= xfer_cnt + LEN_WIDTH'(1);
      end
    end
  end

  pe_feeder_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (gbuf_rd_data),
    .pop       (pop),
    .head      (pe_data),
    .empty     (buf_empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      len_r               <= '0;
      cmd_ready           <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
      pe_start_load       <= 1'b0;
      pe_load_full_column <= 1'b0;
    end else begin
      pe_start_load <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            len_r     <= cmd_len;
            cmd_ready <= 1'b0;
            if (cmd_len != '0) begin
              state               <= START;
              busy                <= 1'b1;
              pe_start_load       <= 1'b1;
              pe_load_full_column <= cmd_full_column;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        START: state <= STREAM;
        STREAM: begin
          if (pop && ((xfer_cnt + LEN_WIDTH'(1)) == len_r)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state               <= IDLE;
          cmd_ready           <= 1'b1;
          pe_load_full_column <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_bus_feeder.sv
// Directed self-checking bench for pe_bus_feeder: per-cycle event log relative to command accept.
module tb_pe_bus_feeder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int NC = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_full_column;
  logic [AW-1:0] cmd_stride;
  logic          gbuf_rd_en;
  logic [AW-1:0] gbuf_rd_addr;
  logic [DW-1:0] gbuf_rd_data;
  logic          pe_start_load;
  logic          pe_load_full_column;
  logic [DW-1:0] pe_data;
  logic          pe_data_en;
  logic          pe_fifo_full;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pe_bus_feeder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_base_addr       (cmd_base_addr),
    .cmd_len             (cmd_len),
    .cmd_full_column     (cmd_full_column),
`ifdef PE_FEEDER_STRIDE_EN
    .cmd_stride          (cmd_stride),
`endif
    .gbuf_rd_en          (gbuf_rd_en),
    .gbuf_rd_addr        (gbuf_rd_addr),
    .gbuf_rd_data        (gbuf_rd_data),
    .pe_start_load       (pe_start_load),
    .pe_load_full_column (pe_load_full_column),
    .pe_data             (pe_data),
    .pe_data_en          (pe_data_en),
    .pe_fifo_full        (pe_fifo_full),
    .busy                (busy),
    .done                (done)
  );

  // GBUF model: one-cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (gbuf_rd_en) gbuf_rd_data <= mem[gbuf_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            base_cyc = 0;
  bit            capturing = 1'b0;
  bit            en_at [NC];
  bit            start_at [NC];
  bit            done_at [NC];
  bit            fc_at [NC];
  bit            ready_at [NC];
  bit            rd_at [NC];
  bit            busy_at [NC];
  logic [DW-1:0] data_at [NC];
  logic [DW-1:0] words [$];
  logic [AW-1:0] addrs [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Mid-cycle sampling of every output, indexed by cycle number after the accept cycle
  always @(negedge clk) begin
    int rel;
    if (capturing) begin
      rel = cyc - base_cyc;
      if (rel >= 0 && rel < NC) begin
        en_at[rel]    = pe_data_en;
        start_at[rel] = pe_start_load;
        done_at[rel]  = done;
        fc_at[rel]    = pe_load_full_column;
        ready_at[rel] = cmd_ready;
        rd_at[rel]    = gbuf_rd_en;
        busy_at[rel]  = busy;
        data_at[rel]  = pe_data;
      end
      if (pe_data_en) words.push_back(pe_data);
      if (gbuf_rd_en) addrs.push_back(gbuf_rd_addr);
    end
  end

  task automatic clearLog();
    for (int i = 0; i < NC; i++) begin
      en_at[i] = 0; start_at[i] = 0; done_at[i] = 0; fc_at[i] = 0;
      ready_at[i] = 0; rd_at[i] = 0; busy_at[i] = 0; data_at[i] = '0;
    end
    words.delete();
    addrs.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command in cycle 0 and runs ncyc further cycles; pe_fifo_full high in cycles full_lo..full_hi
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic fc,
                               input logic [AW-1:0] stride, input int full_lo, input int full_hi,
                               input int ncyc);
    clearLog();
    @(posedge clk);
    #1;
    cmd_base_addr   = base;
    cmd_len         = len;
    cmd_full_column = fc;
    cmd_stride      = stride;
    cmd_valid       = 1'b1;
    pe_fifo_full    = 1'b0;
    base_cyc        = cyc;
    capturing       = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      cmd_valid    = 1'b0;
      pe_fifo_full = (i >= full_lo) && (i <= full_hi);
    end
  endtask

  task automatic countOf(input string tag, input int which, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < NC; i++) begin
      case (which)
        0: n += int'(start_at[i]);
        1: n += int'(rd_at[i]);
        2: n += int'(en_at[i]);
        default: n += int'(done_at[i]);
      endcase
    end
    checkOutput(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0; cmd_full_column = 1'b0;
    cmd_stride = AW'(1); pe_fifo_full = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_start", 32'(pe_start_load), 0);
    checkOutput("rst_fc", 32'(pe_load_full_column), 0);
    checkOutput("rst_data_en", 32'(pe_data_en), 0);
    checkOutput("rst_rd_en", 32'(gbuf_rd_en), 0);
    checkOutput("rst_data", 32'(pe_data), 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Basic stream: base 1, len 6, full column
    $display("[TB] basic stream");
    applyStimulus(AW'(1), LW'(6), 1'b1, AW'(1), -1, -1, 11);
    checkOutput("basic_start_c1", 32'(start_at[1]), 1);
    countOf("basic_start_count", 0, 1);
    for (int c = 3; c <= 8; c++) begin
      checkOutput($sformatf("basic_en_c%0d", c), 32'(en_at[c]), 1);
      checkOutput($sformatf("basic_data_c%0d", c), 32'(data_at[c]), 32'(c - 2));
    end
    checkOutput("basic_en_c2", 32'(en_at[2]), 0);
    checkOutput("basic_en_c9", 32'(en_at[9]), 0);
    countOf("basic_en_count", 2, 6);
    countOf("basic_rd_count", 1, 6);
    checkOutput("basic_done_c9", 32'(done_at[9]), 1);
    countOf("basic_done_count", 3, 1);
    checkOutput("basic_ready_c1", 32'(ready_at[1]), 0);
    checkOutput("basic_ready_c9", 32'(ready_at[9]), 0);
    checkOutput("basic_ready_c10", 32'(ready_at[10]), 1);
    for (int c = 1; c <= 9; c++) checkOutput($sformatf("basic_fc_c%0d", c), 32'(fc_at[c]), 1);
    checkOutput("basic_fc_c10", 32'(fc_at[10]), 0);
    checkOutput("basic_busy_c1", 32'(busy_at[1]), 1);
    checkOutput("basic_busy_c8", 32'(busy_at[8]), 1);
    checkOutput("basic_busy_c9", 32'(busy_at[9]), 0);

    // Backpressure: FIFO full in cycles 4..7
    $display("[TB] backpressure");
    applyStimulus(AW'(1), LW'(6), 1'b1, AW'(1), 4, 7, 15);
    checkOutput("bp_data_c3", 32'(data_at[3]), 1);
    for (int c = 4; c <= 7; c++) begin
      checkOutput($sformatf("bp_en_c%0d", c), 32'(en_at[c]), 0);
      checkOutput($sformatf("bp_hold_c%0d", c), 32'(data_at[c]), 2);
      checkOutput($sformatf("bp_rd_c%0d", c), 32'(rd_at[c]), 0);
    end
    checkOutput("bp_rd_c8", 32'(rd_at[8]), 1);
    for (int c = 8; c <= 12; c++) checkOutput($sformatf("bp_data_c%0d", c), 32'(data_at[c]), 32'(c - 6));
    checkOutput("bp_word_count", 32'(words.size()), 6);
    for (int i = 0; i < words.size() && i < 6; i++)
      checkOutput($sformatf("bp_word%0d", i), 32'(words[i]), 32'(i + 1));
    checkOutput("bp_done_c12", 32'(done_at[12]), 0);
    checkOutput("bp_done_c13", 32'(done_at[13]), 1);

    // Zero length command
    $display("[TB] zero length");
    applyStimulus(AW'(5), LW'(0), 1'b1, AW'(1), -1, -1, 4);
    countOf("zero_start_count", 0, 0);
    countOf("zero_rd_count", 1, 0);
    countOf("zero_en_count", 2, 0);
    checkOutput("zero_done_c1", 32'(done_at[1]), 1);
    checkOutput("zero_busy_c1", 32'(busy_at[1]), 0);
    checkOutput("zero_ready_c1", 32'(ready_at[1]), 0);
    checkOutput("zero_ready_c2", 32'(ready_at[2]), 1);
    checkOutput("zero_fc_c1", 32'(fc_at[1]), 0);

    // Address wrap-around
    $display("[TB] wrap-around");
    applyStimulus(AW'(254), LW'(4), 1'b0, AW'(1), -1, -1, 10);
    checkOutput("wrap_addr_count", 32'(addrs.size()), 4);
    checkOutput("wrap_word_count", 32'(words.size()), 4);
    for (int i = 0; i < 4 && i < addrs.size() && i < words.size(); i++) begin
      logic [AW-1:0] ea;
      ea = AW'(254 + i * int'(cmd_stride));
      checkOutput($sformatf("wrap_addr%0d", i), 32'(addrs[i]), 32'(ea));
      checkOutput($sformatf("wrap_word%0d", i), 32'(words[i]), 32'(mem[ea]));
    end
    checkOutput("wrap_fc_c1", 32'(fc_at[1]), 0);
    checkOutput("wrap_done_c7", 32'(done_at[7]), 1);

    // Reset mid-command after the third word
    $display("[TB] reset mid-operation");
    applyStimulus(AW'(1), LW'(6), 1'b1, AW'(1), -1, -1, 6);
    checkOutput("mid_words_before", 32'(words.size()), 3);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_rd_en", 32'(gbuf_rd_en), 0);
    checkOutput("mid_data_en", 32'(pe_data_en), 0);
    checkOutput("mid_data", 32'(pe_data), 0);
    checkOutput("mid_fc", 32'(pe_load_full_column), 0);
    checkOutput("mid_rd_addr", 32'(gbuf_rd_addr), 0);
    capturing = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus(AW'(1), LW'(2), 1'b0, AW'(1), -1, -1, 7);
    checkOutput("post_word_count", 32'(words.size()), 2);
    for (int i = 0; i < 2 && i < words.size(); i++)
      checkOutput($sformatf("post_word%0d", i), 32'(words[i]), 32'(i + 1));
    checkOutput("post_en_c3", 32'(en_at[3]), 1);
    checkOutput("post_done_c5", 32'(done_at[5]), 1);

`ifdef PE_FEEDER_STRIDE_EN
    // Strided read
    $display("[TB] stride");
    applyStimulus(AW'(0), LW'(3), 1'b0, AW'(12), -1, -1, 9);
    checkOutput("stride_addr_count", 32'(addrs.size()), 3);
    for (int i = 0; i < 3 && i < addrs.size() && i < words.size(); i++) begin
      checkOutput($sformatf("stride_addr%0d", i), 32'(addrs[i]), 32'(i * 12));
      checkOutput($sformatf("stride_word%0d", i), 32'(words[i]), 32'(mem[i * 12]));
    end
`endif

    capturing = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_bus_feeder.md
Name: pe_bus_feeder

Overview:
- Bus-side transmitter that streams fmap or weight words from a global buffer (GBUF) into one PE input port.
- It implements in hardware the protocol the PE expects:
  - a one-cycle start-load pulse, plus the load-full-column level;
  - then words, with each word's enable gated by the PE FIFO-full flag.
- Sits between the GBUF read port and a PE's feature_in/weight_in interface. One instance is used per stream (fmap and weight).

Parameters:
- DATA_WIDTH, 16, width of a GBUF word and of PE data.
- ADDR_WIDTH, 8, GBUF address width.
- LEN_WIDTH, 8, width of the command word count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_base_addr  in  ADDR_WIDTH  first GBUF address
- cmd_len  in  LEN_WIDTH  number of words to send (0 = no-op)
- cmd_full_column  in  1  value driven on pe_load_full_column for this command
- gbuf_rd_en  out  1  GBUF read strobe
- gbuf_rd_addr  out  ADDR_WIDTH  GBUF read address
- gbuf_rd_data  in  DATA_WIDTH  read data, valid the cycle after gbuf_rd_en
- pe_start_load  out  1  one-cycle start pulse to the PE (start_feature_load / start_weight_load)
- pe_load_full_column  out  1  level, held for the whole command
- pe_data  out  DATA_WIDTH  word to the PE
- pe_data_en  out  1  word transferred this cycle
- pe_fifo_full  in  1  PE input FIFO full (fifo_full_fmap / fifo_full_filter)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after the last word is transferred

Behaviour:
- Reset values: every output is 0, except cmd_ready=1.
  - Reset asserted mid-command aborts the command immediately.
  - It clears the skid buffer, the in-flight flag and the counters; a late gbuf_rd_data is discarded.
- FSM states: IDLE, START, STREAM, DONE.
  - IDLE: cmd_ready=1. On accept, latch base, len and full_column.
    - len≠0 → START.
    - len=0 → DONE: no start pulse, no reads.
  - START (1 cycle): pe_start_load=1, pe_load_full_column=latched value, first read issued. → STREAM.
  - STREAM: continue reads and transfers. When transferred count == len → DONE.
  - DONE (1 cycle): done=1, busy=0. → IDLE. pe_load_full_column returns to 0 on entering IDLE.
- busy=1 in START and STREAM.
- Read path:
  - Read issued in cycle N; data captured into a 2-entry skid buffer at the end of cycle N+1; presentable from cycle N+2.
  - A read is issued only while issued < len AND (occupancy + in_flight − pop_this_cycle) < 2.
  - This guarantees the buffer never overflows.
- Address arithmetic: address increments by 1 per read, modulo 2^ADDR_WIDTH (wrap-around, no error).
- PE handshake:
  - pe_data_en = buffer_not_empty & !pe_fifo_full. This is combinational from pe_fifo_full, matching the PE's same-cycle sampling.
  - pe_data = buffer head. It is held stable while pe_fifo_full=1.
  - No word is lost or duplicated.
- Throughput: 1 word/cycle while pe_fifo_full=0.
- Latency: with accept in cycle 0, the first pe_data_en is in cycle 3.
- Simultaneous capture and pop in one cycle: occupancy is unchanged.
- cmd_valid outside IDLE is ignored: cmd_ready=0.

Optional Feature:
- Macro PE_FEEDER_STRIDE_EN.
- Defined:
  - adds input port cmd_stride (ADDR_WIDTH), latched on accept;
  - the address advances by cmd_stride per read, modulo 2^ADDR_WIDTH;
  - stride 0 re-reads the same address len times.
- Undefined: the port is absent and the stride is fixed at 1.

Decomposition:
- Package pe_feeder_pkg: FSM state enum (IDLE, START, STREAM, DONE) and constant SKID_DEPTH=2.
- Sub-module pe_feeder_skid_buf: 2-entry DATA_WIDTH buffer with push, pop, empty and occupancy outputs.
- The top module holds the FSM, counters, address generator and read-issue logic.

Test Plan:
- Basic stream:
  - Stimulus: GBUF[a]=a; cmd base=1, len=6, full_column=1; pe_fifo_full=0.
  - Response: pe_start_load in cycle 1; pe_data 1..6 with pe_data_en in cycles 3..8; done in cycle 9; cmd_ready=1 in cycle 10; pe_load_full_column=1 in cycles 1..9.
- Backpressure:
  - Stimulus: same command, with pe_fifo_full=1 in cycles 4..7.
  - Response: pe_data_en=0 and pe_data held at 2 in cycles 4..7; gbuf_rd_en drops once the buffer is full; output sequence exactly 1..6; done in cycle 13.
- Zero length:
  - Stimulus: cmd len=0.
  - Response: no pe_start_load, no gbuf_rd_en, no pe_data_en; done in cycle 1; cmd_ready in cycle 2.
- Wrap-around:
  - Stimulus: base=254, len=4.
  - Response: gbuf_rd_addr sequence 254, 255, 0, 1; pe_data = GBUF values in order.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after the 3rd word of a len=6 command.
  - Response: all outputs 0 and cmd_ready=1 immediately; a new command base=1, len=2 delivers exactly 1, 2 with no stale word.
- With PE_FEEDER_STRIDE_EN:
  - Stimulus: base=0, len=3, stride=12.
  - Response: gbuf_rd_addr 0, 12, 24; pe_data = GBUF[0], GBUF[12], GBUF[24].
